cpu_bus_sync: RTL and testbench
===============================

// Module: cpu_bus_sync
// PURPOSE
//  Front end between the asynchronous NES CPU cartridge bus pins and the mapper map_bus.
//  - Synchronises M2, R/W, address and data into the cart clock domain.
//  - Deglitches M2 and emits single-cycle rise/fall event strobes.
//  - Holds stable captured address/R/W/data per CPU cycle for the mapper.
//  - Flags loss of M2 (console reset / power-down) so mapper registers can be cleared.
// PARAMETERS
//  SYNC_STAGES    2     flip-flop synchroniser depth on every input pin (>=2)
//  M2_FILTER      3     consecutive equal synced M2 samples required to accept a level change (>=1)
//  TIMEOUT_CYCLES 1024  clk cycles with no accepted M2 rise before cpu_idle asserts
//  ADDR_W         16    CPU address width
//  DATA_W         8     CPU data width
// PORTS
//  clk          in   1       cart system clock; the block's single clock
//  rst_n        in   1       asynchronous, active-low reset
//  m2_in        in   1       raw M2 pin (async)
//  cpu_rw_in    in   1       raw R/W pin, 1 = read (async)
//  cpu_addr_in  in   ADDR_W  raw address pins (async)
//  cpu_data_in  in   DATA_W  raw data pins (async)
//  m2           out  1       filtered M2 level
//  m2_rise      out  1       1-clk pulse on accepted M2 0->1
//  m2_fall      out  1       1-clk pulse on accepted M2 1->0
//  cpu_addr     out  ADDR_W  address captured at m2_rise
//  cpu_rw       out  1       R/W captured at m2_rise
//  cpu_data     out  DATA_W  data captured at m2_fall; last synced sample while M2 was high
//  rd_start     out  1       pulse with m2_rise when captured R/W = 1
//  wr_strobe    out  1       pulse with m2_fall when cpu_rw = 0; cpu_data valid in the same cycle
//  cpu_idle     out  1       high while M2 is lost (timeout)
// BEHAVIOUR
//  - Reset (async assert, sync release): m2 = 0, all pulses = 0, cpu_addr = 0, cpu_data = 0,
//    cpu_rw = 1, cpu_idle = 1. Filter state = M2_LOW, counters = 0, synchronisers cleared to 0.
//  - Every input bit passes through SYNC_STAGES flops. Filtering applies to M2 only.
//  - Filter FSM, states M2_LOW / M2_HIGH, counter flt_cnt:
//    - In M2_LOW, a synced M2 of 1 increments flt_cnt; a synced 0 clears it.
//    - When flt_cnt reaches M2_FILTER: move to M2_HIGH, clear flt_cnt, pulse m2_rise.
//    - M2_HIGH is symmetric and pulses m2_fall.
//    - A glitch shorter than M2_FILTER samples produces no event.
//  - Latency: input edge to strobe = SYNC_STAGES + M2_FILTER clk cycles.
//  - At m2_rise: cpu_addr and cpu_rw load the synced samples from the same cycle.
//  - last_hi_data register: loads synced data on every cycle where synced M2 = 1. At m2_fall it
//    copies into cpu_data. This keeps the write data as seen before the falling edge, unaffected
//    by the data-bus float during filter latency.
//  - rd_start = m2_rise & synced R/W. wr_strobe = m2_fall & !cpu_rw. Both are never asserted
//    in the same cycle.
//  - m2_rise and m2_fall are mutually exclusive. At least M2_FILTER cycles separate them.
//  - Timeout counter:
//    - Cleared at every m2_rise; otherwise increments, saturating at TIMEOUT_CYCLES.
//    - cpu_idle sets when the count reaches TIMEOUT_CYCLES.
//    - cpu_idle clears in the same cycle as the next m2_rise.
//  - Count widths: $clog2(M2_FILTER+1) and $clog2(TIMEOUT_CYCLES+1).
//  - Reset asserted mid-cycle aborts any pending edge. No strobe is emitted on release until a
//    full filtered edge is seen.
// STRUCTURE
//  - Package cpu_bus_pkg: typedef enum logic {M2_LOW, M2_HIGH} m2_state_t; default constants
//    CPU_ADDR_W = 16 and CPU_DATA_W = 8.
//  - Sub-module sync_filter (params STAGES, FILTER) implements the 1-bit synchroniser plus the
//    debounce FSM. It is instantiated once, for M2. Address, data and R/W use plain
//    synchroniser arrays in the top module.
// TESTING
//  - Reset: hold rst_n = 0 with M2 toggling -> all outputs at reset values, no strobes.
//    Release -> first m2_rise appears exactly 5 clks after the next M2 rise (defaults).
//  - Write cycle: addr = 16'h8000, rw = 0, data = 8'h05 driven during M2 high.
//    Data bus goes to 8'hFF 1 clk after M2 falls -> wr_strobe once, cpu_addr = 16'h8000,
//    cpu_data = 8'h05.
//  - Read cycle: addr = 16'hC123, rw = 1 -> rd_start coincides with m2_rise,
//    cpu_addr = 16'hC123, no wr_strobe.
//  - Glitch: M2 high for 2 clks inside a low phase -> no m2_rise and no state change.
//    M2 high for 3 clks -> exactly one m2_rise.
//  - Timeout: stop M2 for 1024 clks -> cpu_idle rises on that cycle. Resume M2 -> cpu_idle
//    drops at the first m2_rise.
//  - Back-to-back: 100 cycles with random addr/data/rw at a 56-clk M2 period -> one
//    rise/fall pair per cycle, captured values match a scoreboard.

Source files
------------

// File: rtl/cpu_bus_sync_pkg.sv
// Shared types and default widths for the CPU cartridge bus front end.
//   m2_state_t  : M2 debounce FSM state (M2_LOW / M2_HIGH)
//   CPU_ADDR_W  : default CPU address width
//   CPU_DATA_W  : default CPU data width
package cpu_bus_pkg;

    typedef enum logic {M2_LOW, M2_HIGH} m2_state_t;

    localparam int CPU_ADDR_W = 16;
    localparam int CPU_DATA_W = 8;

endpackage

// File: rtl/cpu_bus_sync_filter.sv
// 1-bit synchroniser followed by a level debounce FSM (used for M2).
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : raw asynchronous input
//   q_sync     : synchronised (unfiltered) sample
//   level      : filtered level
//   rise, fall : registered 1-clk pulses on accepted 0->1 / 1->0
//   rise_evt,
//   fall_evt   : combinational "edge accepted this cycle"; they become
//                rise/fall on the next clock, letting the parent capture
//                data on the same edge the pulse is registered
module sync_filter
    import cpu_bus_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int FILTER = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q_sync,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_evt,
    output logic fall_evt
);

    localparam int CW = $clog2(FILTER + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

    logic [STAGES-1:0] sync_q;
    m2_state_t         state, state_next;
    logic [CW-1:0]     cnt, cnt_next;

    assign q_sync = sync_q[STAGES-1];
    assign level  = (state == M2_HIGH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            state  <= M2_LOW;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            state  <= state_next;
            cnt    <= cnt_next;
            rise   <= rise_evt;
            fall   <= fall_evt;
        end
    end

    // cnt counts consecutive samples that disagree with the current level;
    // the FILTER-th such sample flips the level.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rise_evt   = 1'b0;
        fall_evt   = 1'b0;
        case (state)
            M2_LOW: begin
                if (q_sync) begin
                    if (cnt == CNT_LAST) begin
                        state_next = M2_HIGH;
                        cnt_next   = '0;
                        rise_evt   = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            M2_HIGH: begin
                if (!q_sync) begin
                    if (cnt == CNT_LAST) begin
                        state_next = M2_LOW;
                        cnt_next   = '0;
                        fall_evt   = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end else begin
                    cnt_next = '0;
                end
            end
        endcase
    end

endmodule

// File: rtl/cpu_bus_sync.sv
// Front end between the asynchronous NES CPU cartridge bus and the mapper.
// Synchronises all pins, deglitches M2, captures address/R/W at the M2 rise
// and write data at the M2 fall, and flags loss of M2.
//   clk, rst_n   : cart clock, asynchronous active-low reset
//   m2_in        : raw M2 pin
//   cpu_rw_in    : raw R/W pin (1 = read)
//   cpu_addr_in  : raw address pins
//   cpu_data_in  : raw data pins
//   m2           : filtered M2 level
//   m2_rise/fall : 1-clk pulses on accepted M2 edges
//   cpu_addr     : address captured at m2_rise
//   cpu_rw       : R/W captured at m2_rise
//   cpu_data     : last synced data seen while M2 was high, captured at m2_fall
//   rd_start     : m2_rise of a read cycle
//   wr_strobe    : m2_fall of a write cycle (cpu_data valid in the same cycle)
//   cpu_idle     : high while no M2 rise has been accepted for TIMEOUT_CYCLES
module cpu_bus_sync
    import cpu_bus_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int M2_FILTER      = 3,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ADDR_W         = CPU_ADDR_W,
    parameter int DATA_W         = CPU_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m2_in,
    input  logic              cpu_rw_in,
    input  logic [ADDR_W-1:0] cpu_addr_in,
    input  logic [DATA_W-1:0] cpu_data_in,
    output logic              m2,
    output logic              m2_rise,
    output logic              m2_fall,
    output logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_rw,
    output logic [DATA_W-1:0] cpu_data,
    output logic              rd_start,
    output logic              wr_strobe,
    output logic              cpu_idle
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0]             rw_q;
    logic [SYNC_STAGES-1:0][ADDR_W-1:0] addr_q;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] data_q;

    logic              rw_sync;
    logic [ADDR_W-1:0] addr_sync;
    logic [DATA_W-1:0] data_sync;
    logic              m2_sync;
    logic              rise_evt, fall_evt;
    logic [DATA_W-1:0] last_hi_data;
    logic [TW-1:0]     to_cnt;

    sync_filter #(
        .STAGES (SYNC_STAGES),
        .FILTER (M2_FILTER)
    ) u_m2_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (m2_in),
        .q_sync   (m2_sync),
        .level    (m2),
        .rise     (m2_rise),
        .fall     (m2_fall),
        .rise_evt (rise_evt),
        .fall_evt (fall_evt)
    );

    assign rw_sync   = rw_q[SYNC_STAGES-1];
    assign addr_sync = addr_q[SYNC_STAGES-1];
    assign data_sync = data_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            rw_q   <= {rw_q[SYNC_STAGES-2:0], cpu_rw_in};
            addr_q <= {addr_q[SYNC_STAGES-2:0], cpu_addr_in};
            data_q <= {data_q[SYNC_STAGES-2:0], cpu_data_in};
        end
    end

    // Captures use the filter's pre-registered events so captured values
    // appear in the same cycle as the corresponding strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_addr     <= '0;
            cpu_rw       <= 1'b1;
            cpu_data     <= '0;
            last_hi_data <= '0;
        end else begin
            if (rise_evt) begin
                cpu_addr <= addr_sync;
                cpu_rw   <= rw_sync;
            end
            // Tracks data only while synced M2 is high, so the bus float
            // during the fall filter latency never reaches cpu_data.
            if (m2_sync) begin
                last_hi_data <= data_sync;
            end
            if (fall_evt) begin
                cpu_data <= last_hi_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt   <= '0;
            cpu_idle <= 1'b1;
        end else if (rise_evt) begin
            to_cnt   <= '0;
            cpu_idle <= 1'b0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_LAST) begin
                cpu_idle <= 1'b1;
            end
        end
    end

    assign rd_start  = m2_rise & cpu_rw;
    assign wr_strobe = m2_fall & ~cpu_rw;

endmodule

// File: tb/tb_cpu_bus_sync.sv
module tb_cpu_bus_sync;

    logic        clk;
    logic        rst_n;
    logic        m2_in;
    logic        cpu_rw_in;
    logic [15:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic        m2;
    logic        m2_rise;
    logic        m2_fall;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_data;
    logic        rd_start;
    logic        wr_strobe;
    logic        cpu_idle;

    cpu_bus_sync dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m2_in       (m2_in),
        .cpu_rw_in   (cpu_rw_in),
        .cpu_addr_in (cpu_addr_in),
        .cpu_data_in (cpu_data_in),
        .m2          (m2),
        .m2_rise     (m2_rise),
        .m2_fall     (m2_fall),
        .cpu_addr    (cpu_addr),
        .cpu_rw      (cpu_rw),
        .cpu_data    (cpu_data),
        .rd_start    (rd_start),
        .wr_strobe   (wr_strobe),
        .cpu_idle    (cpu_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int t_hi     = 0;
    int t_lo     = 0;
    int n_rise   = 0, n_fall = 0, n_rd = 0, n_wr = 0, n_clash = 0, n_m2hi = 0;
    int b_rise   = 0, b_fall = 0, b_rd = 0, b_wr = 0, b_m2hi = 0;
    int rise_lat = 0, fall_lat = 0, rise_cyc = 0;
    logic [15:0] r_addr;
    logic        r_rw;
    logic [7:0]  r_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; samples outputs 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (m2) n_m2hi++;
        if (m2_rise) begin
            n_rise++;
            rise_lat = cyc - t_hi;
            rise_cyc = cyc;
            r_addr   = cpu_addr;
            r_rw     = cpu_rw;
        end
        if (m2_fall) begin
            n_fall++;
            fall_lat = cyc - t_lo;
        end
        if (rd_start) n_rd++;
        if (wr_strobe) begin
            n_wr++;
            r_wdata = cpu_data;
        end
        if (m2_rise && m2_fall) n_clash++;
        if (rd_start && wr_strobe) n_clash++;
        if (rd_start && !m2_rise) n_clash++;
        if (wr_strobe && !m2_fall) n_clash++;
    endtask

    task automatic mark();
        b_rise = n_rise;
        b_fall = n_fall;
        b_rd   = n_rd;
        b_wr   = n_wr;
        b_m2hi = n_m2hi;
    endtask

    // Data bus floats to FF one clock after M2 drops.
    task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d,
                             input int hi, input int lo);
        cpu_addr_in = a;
        cpu_rw_in   = rw;
        cpu_data_in = d;
        m2_in       = 1'b1;
        t_hi        = cyc;
        repeat (hi) tick();
        m2_in = 1'b0;
        t_lo  = cyc;
        tick();
        cpu_data_in = 8'hFF;
        repeat (lo - 1) tick();
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  d;
        logic        rw;

        rst_n       = 1'b0;
        m2_in       = 1'b0;
        cpu_rw_in   = 1'b0;
        cpu_addr_in = 16'h1234;
        cpu_data_in = 8'h5A;

        // Reset held with M2 toggling
        mark();
        for (int i = 0; i < 12; i++) begin
            m2_in = i[1];
            tick();
        end
        check("rst_rise_cnt", 32'(n_rise - b_rise), 32'd0);
        check("rst_fall_cnt", 32'(n_fall - b_fall), 32'd0);
        check("rst_rdwr_cnt", 32'(n_rd + n_wr), 32'd0);
        check("rst_m2", 32'(m2), 32'd0);
        check("rst_addr", 32'(cpu_addr), 32'h0);
        check("rst_data", 32'(cpu_data), 32'h0);
        check("rst_rw", 32'(cpu_rw), 32'd1);
        check("rst_idle", 32'(cpu_idle), 32'd1);

        m2_in = 1'b0;
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_rst_idle", 32'(cpu_idle), 32'd1);
        check("post_rst_rise", 32'(n_rise), 32'd0);

        // Write cycle
        mark();
        bus_cycle(16'h8000, 1'b0, 8'h05, 20, 20);
        check("wr_rise_lat", 32'(rise_lat), 32'd5);
        check("wr_fall_lat", 32'(fall_lat), 32'd5);
        check("wr_rise_cnt", 32'(n_rise - b_rise), 32'd1);
        check("wr_strobe_cnt", 32'(n_wr - b_wr), 32'd1);
        check("wr_rd_cnt", 32'(n_rd - b_rd), 32'd0);
        check("wr_addr", 32'(r_addr), 32'h8000);
        check("wr_rw", 32'(r_rw), 32'd0);
        check("wr_data", 32'(r_wdata), 32'h05);
        check("wr_cpu_data_hold", 32'(cpu_data), 32'h05);
        check("wr_idle", 32'(cpu_idle), 32'd0);

        // Read cycle
        mark();
        bus_cycle(16'hC123, 1'b1, 8'hAA, 20, 20);
        check("rd_start_cnt", 32'(n_rd - b_rd), 32'd1);
        check("rd_wr_cnt", 32'(n_wr - b_wr), 32'd0);
        check("rd_addr", 32'(r_addr), 32'hC123);
        check("rd_rw", 32'(r_rw), 32'd1);
        check("rd_rise_lat", 32'(rise_lat), 32'd5);

        // 2-clk glitch: filtered away
        mark();
        m2_in = 1'b1;
        repeat (2) tick();
        m2_in = 1'b0;
        repeat (10) tick();
        check("glitch2_rise", 32'(n_rise - b_rise), 32'd0);
        check("glitch2_fall", 32'(n_fall - b_fall), 32'd0);
        check("glitch2_m2hi", 32'(n_m2hi - b_m2hi), 32'd0);

        // 3-clk pulse: exactly one rise
        mark();
        m2_in = 1'b1;
        t_hi  = cyc;
        repeat (3) tick();
        m2_in = 1'b0;
        t_lo  = cyc;
        repeat (2) tick();
        check("pulse3_rise", 32'(n_rise - b_rise), 32'd1);
        check("pulse3_lat", 32'(rise_lat), 32'd5);

        // Timeout: M2 stays low from here
        while (cyc < rise_cyc + 1023) tick();
        check("to_idle_before", 32'(cpu_idle), 32'd0);
        tick();
        check("to_idle_at", 32'(cpu_idle), 32'd1);
        repeat (20) tick();
        check("to_idle_hold", 32'(cpu_idle), 32'd1);
        m2_in = 1'b1;
        t_hi  = cyc;
        repeat (4) tick();
        check("resume_idle_pre", 32'(cpu_idle), 32'd1);
        check("resume_rise_pre", 32'(m2_rise), 32'd0);
        tick();
        check("resume_rise", 32'(m2_rise), 32'd1);
        check("resume_idle", 32'(cpu_idle), 32'd0);
        m2_in = 1'b0;
        repeat (30) tick();

        // Back-to-back cycles, 56-clk M2 period
        for (int k = 0; k < 100; k++) begin
            a  = 16'($urandom);
            d  = 8'($urandom);
            rw = 1'($urandom_range(0, 1));
            mark();
            bus_cycle(a, rw, d, 28, 28);
            check("b2b_rise", 32'(n_rise - b_rise), 32'd1);
            check("b2b_fall", 32'(n_fall - b_fall), 32'd1);
            check("b2b_addr", 32'(r_addr), 32'(a));
            check("b2b_rw", 32'(r_rw), 32'(rw));
            check("b2b_rd", 32'(n_rd - b_rd), 32'(rw));
            check("b2b_wr", 32'(n_wr - b_wr), 32'(!rw));
            if (!rw) check("b2b_data", 32'(r_wdata), 32'(d));
        end

        // Reset mid-filter aborts the pending edge
        mark();
        m2_in = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        m2_in = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("abort_rise", 32'(n_rise - b_rise), 32'd0);
        check("abort_fall", 32'(n_fall - b_fall), 32'd0);
        check("abort_idle", 32'(cpu_idle), 32'd1);
        check("abort_addr", 32'(cpu_addr), 32'h0);

        check("no_clash", 32'(n_clash), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
